rename_stage: RTL and testbench

Parametrised WIDTH-lane rename stage between the instruction queue and dispatch, replacing the single-lane-rename decode/rename path. Each cycle it renames a whole bundle: per-lane free-list allocation, intra-bundle RAW bypass and WAW-filtered RAT writes. It notifies the ROB and registers the renamed bundle into a one-entry pipeline register with a valid/ready handshake toward dispatch. It supports a flush from the backend.

---
 rtl/rename_stage.sv | 194 +++++++++++++++++++
 tb/tb_rename_stage.sv | 420 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rename_stage.sv
// WIDTH-lane register rename stage: free-list allocation, intra-bundle RAW bypass,
// WAW-filtered RAT writes and a one-entry output register. Stall counters: RENAME_STATS_EN.
module rename_stage #(
  parameter int WIDTH   = 2,
  parameter int ARF_IDX = 5,
  parameter int PRF_IDX = 6,
  parameter int ROB_IDX = 5
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           flush,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [WIDTH-1:0]               in_lane_valid,
  input  logic [WIDTH*ARF_IDX-1:0]       in_rd_arch,
  input  logic [WIDTH*ARF_IDX-1:0]       in_rs1_arch,
  input  logic [WIDTH*ARF_IDX-1:0]       in_rs2_arch,
  input  logic [WIDTH*PRF_IDX-1:0]       fl_free_idx,
  input  logic [$clog2(WIDTH+1)-1:0]     fl_avail_cnt,
  output logic [WIDTH-1:0]               fl_pop,
  output logic [2*WIDTH*ARF_IDX-1:0]     rat_read_arch,
  input  logic [2*WIDTH*PRF_IDX-1:0]     rat_read_phy,
  input  logic [2*WIDTH-1:0]             rat_read_valid,
  output logic [WIDTH-1:0]               rat_we,
  output logic [WIDTH*ARF_IDX-1:0]       rat_waddr,
  output logic [WIDTH*PRF_IDX-1:0]       rat_wphy,
  output logic                           rob_valid,
  input  logic                           rob_ready,
  input  logic [WIDTH*ROB_IDX-1:0]       rob_id,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [WIDTH-1:0]               out_lane_valid,
  output logic [WIDTH*PRF_IDX-1:0]       out_rd_phy,
  output logic [WIDTH*PRF_IDX-1:0]       out_rs1_phy,
  output logic [WIDTH*PRF_IDX-1:0]       out_rs2_phy,
  output logic [WIDTH-1:0]               out_rs1_valid,
  output logic [WIDTH-1:0]               out_rs2_valid,
  output logic [WIDTH*ROB_IDX-1:0]       out_rob_id
`ifdef RENAME_STATS_EN
  ,
  output logic [31:0]                    stat_stall_fl,
  output logic [31:0]                    stat_stall_rob,
  output logic [31:0]                    stat_stall_out
`endif
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  logic [WIDTH-1:0][ARF_IDX-1:0]   rd_arch, rs1_arch, rs2_arch;
  logic [WIDTH-1:0][PRF_IDX-1:0]   free_idx;
  logic [2*WIDTH-1:0][PRF_IDX-1:0] rat_phy;
  logic [2*WIDTH-1:0][ARF_IDX-1:0] rd_req;
  logic [WIDTH-1:0][ROB_IDX-1:0]   rob_idx, rob_lane;

  assign rd_arch  = in_rd_arch;
  assign rs1_arch = in_rs1_arch;
  assign rs2_arch = in_rs2_arch;
  assign free_idx = fl_free_idx;
  assign rat_phy  = rat_read_phy;
  assign rob_idx  = rob_id;

  logic [WIDTH-1:0]              alloc;
  logic [WIDTH-1:0][CNT_W-1:0]   slot;
  logic [CNT_W-1:0]              need;
  logic [WIDTH-1:0][PRF_IDX-1:0] rd_phy, rs1_phy, rs2_phy;
  logic [WIDTH-1:0]              rs1_rdy, rs2_rdy;
  logic                          fl_ok, space, fire;

  // Allocating lanes take free-list slots in lane order.
  always_comb begin
    // NOTE: every signal gets a default first so no path can infer a latch.
    alloc  = '0;
    slot   = '0;
    need   = '0;
    rd_phy = '0;
    for (int i = 0; i < WIDTH; i++) begin
      alloc[i] = in_lane_valid[i] && (rd_arch[i] != '0);
      slot[i]  = need;
      if (alloc[i]) need = need + CNT_W'(1);
    end
    for (int i = 0; i < WIDTH; i++)
      for (int k = 0; k < WIDTH; k++)
        if (alloc[i] && slot[i] == CNT_W'(k)) rd_phy[i] = free_idx[k];
  end

  assign fl_ok     = fl_avail_cnt >= need;
  assign space     = !out_valid || out_ready;
  assign in_ready  = !flush && rob_ready && fl_ok && space;
  assign fire      = in_valid && in_ready;
  assign rob_valid = in_valid && !flush && fl_ok && space;

  always_comb begin
    fl_pop = '0;
    for (int k = 0; k < WIDTH; k++) fl_pop[k] = fire && (CNT_W'(k) < need);
  end

  for (genvar g = 0; g < WIDTH; g++) begin : g_req
    assign rd_req[2*g]   = rs1_arch[g];
    assign rd_req[2*g+1] = rs2_arch[g];
  end
  assign rat_read_arch = rd_req;

  // Sources: ascending scan over older lanes lets the youngest producer win.
  always_comb begin
    rs1_phy  = '0;
    rs2_phy  = '0;
    rs1_rdy  = '0;
    rs2_rdy  = '0;
    rob_lane = '0;
    for (int i = 0; i < WIDTH; i++) begin
      rs1_phy[i] = rat_phy[2*i];
      rs1_rdy[i] = rat_read_valid[2*i];
      rs2_phy[i] = rat_phy[2*i+1];
      rs2_rdy[i] = rat_read_valid[2*i+1];
      for (int j = 0; j < i; j++) begin
        if (alloc[j] && rs1_arch[i] != '0 && rd_arch[j] == rs1_arch[i]) begin
          rs1_phy[i] = rd_phy[j];
          rs1_rdy[i] = 1'b0;
        end
        if (alloc[j] && rs2_arch[i] != '0 && rd_arch[j] == rs2_arch[i]) begin
          rs2_phy[i] = rd_phy[j];
          rs2_rdy[i] = 1'b0;
        end
      end
      if (in_lane_valid[i]) begin
        rob_lane[i] = rob_idx[i];
      end else begin
        rs1_phy[i] = '0;
        rs2_phy[i] = '0;
        rs1_rdy[i] = 1'b0;
        rs2_rdy[i] = 1'b0;
      end
    end
  end

  // Only the youngest writer of an arch register updates the RAT.
  always_comb begin
    rat_we = '0;
    for (int i = 0; i < WIDTH; i++) begin
      rat_we[i] = fire && alloc[i];
      for (int k = i + 1; k < WIDTH; k++)
        if (alloc[k] && rd_arch[k] == rd_arch[i]) rat_we[i] = 1'b0;
    end
  end
  assign rat_waddr = in_rd_arch;
  assign rat_wphy  = rd_phy;

  always_ff @(posedge clk) begin
    // NOTE: state uses <= so every register samples pre-edge values regardless of block order.
    if (!rst) begin
      // NOTE: payload is cleared on reset as well, since out_* are observable while out_valid=0.
      out_valid      <= 1'b0;
      out_lane_valid <= '0;
      out_rd_phy     <= '0;
      out_rs1_phy    <= '0;
      out_rs2_phy    <= '0;
      out_rs1_valid  <= '0;
      out_rs2_valid  <= '0;
      out_rob_id     <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (fire) begin
      out_valid      <= 1'b1;
      out_lane_valid <= in_lane_valid;
      out_rd_phy     <= rd_phy;
      out_rs1_phy    <= rs1_phy;
      out_rs2_phy    <= rs2_phy;
      out_rs1_valid  <= rs1_rdy;
      out_rs2_valid  <= rs2_rdy;
      out_rob_id     <= rob_lane;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

`ifdef RENAME_STATS_EN
  logic stall;
  assign stall = in_valid && !fire && !flush;

  // Saturating per-cause stall counters; several causes may count in one cycle.
  always_ff @(posedge clk) begin
    if (!rst) begin
      stat_stall_fl  <= '0;
      stat_stall_rob <= '0;
      stat_stall_out <= '0;
    end else if (stall) begin
      if (!fl_ok && stat_stall_fl != '1)     stat_stall_fl  <= stat_stall_fl + 32'd1;
      if (!rob_ready && stat_stall_rob != '1) stat_stall_rob <= stat_stall_rob + 32'd1;
      if (!space && stat_stall_out != '1)     stat_stall_out <= stat_stall_out + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_rename_stage.sv
// Self-checking bench for rename_stage (WIDTH=2): directed scenarios plus a
// scoreboard monitor comparing every output bundle and combinational handshake.
module tb_rename_stage;
  localparam int W = 2;
  localparam int A = 5;
  localparam int P = 6;
  localparam int R = 5;

  logic clk, rst, flush, in_valid, in_ready, rob_valid, rob_ready, out_valid, out_ready;
  logic [W-1:0]     in_lane_valid, fl_pop, rat_we, out_lane_valid, out_rs1_valid, out_rs2_valid;
  logic [W*A-1:0]   in_rd_arch, in_rs1_arch, in_rs2_arch, rat_waddr;
  logic [W*P-1:0]   fl_free_idx, rat_wphy, out_rd_phy, out_rs1_phy, out_rs2_phy;
  logic [1:0]       fl_avail_cnt;
  logic [2*W*A-1:0] rat_read_arch;
  logic [2*W*P-1:0] rat_read_phy;
  logic [2*W-1:0]   rat_read_valid;
  logic [W*R-1:0]   rob_id, out_rob_id;
`ifdef RENAME_STATS_EN
  logic [31:0] stat_stall_fl, stat_stall_rob, stat_stall_out;
`endif

  rename_stage #(.WIDTH(W), .ARF_IDX(A), .PRF_IDX(P), .ROB_IDX(R)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_lane_valid(in_lane_valid), .in_rd_arch(in_rd_arch), .in_rs1_arch(in_rs1_arch),
    .in_rs2_arch(in_rs2_arch), .fl_free_idx(fl_free_idx), .fl_avail_cnt(fl_avail_cnt),
    .fl_pop(fl_pop), .rat_read_arch(rat_read_arch), .rat_read_phy(rat_read_phy),
    .rat_read_valid(rat_read_valid), .rat_we(rat_we), .rat_waddr(rat_waddr),
    .rat_wphy(rat_wphy), .rob_valid(rob_valid), .rob_ready(rob_ready), .rob_id(rob_id),
    .out_valid(out_valid), .out_ready(out_ready), .out_lane_valid(out_lane_valid),
    .out_rd_phy(out_rd_phy), .out_rs1_phy(out_rs1_phy), .out_rs2_phy(out_rs2_phy),
    .out_rs1_valid(out_rs1_valid), .out_rs2_valid(out_rs2_valid), .out_rob_id(out_rob_id)
`ifdef RENAME_STATS_EN
    , .stat_stall_fl(stat_stall_fl), .stat_stall_rob(stat_stall_rob),
    .stat_stall_out(stat_stall_out)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Fixed RAT contents: arch a maps to phys a+10, ready when a < 16.
  function automatic logic [P-1:0] rat_phy_f(input logic [A-1:0] a);
    return {1'b0, a} + 6'd10;
  endfunction
  function automatic logic rat_rdy_f(input logic [A-1:0] a);
    return !a[4];
  endfunction

  always_comb begin
    rat_read_phy   = '0;
    rat_read_valid = '0;
    for (int s = 0; s < 2*W; s++) begin
      rat_read_phy[s*P +: P] = rat_phy_f(rat_read_arch[s*A +: A]);
      rat_read_valid[s]      = rat_rdy_f(rat_read_arch[s*A +: A]);
    end
  end

  typedef struct {
    logic [W-1:0]   lv;
    logic [W*P-1:0] rd, rs1, rs2;
    logic [W-1:0]   rs1v, rs2v;
    logic [W*R-1:0] rob;
  } bundle_t;

  typedef struct {
    bundle_t      b;
    int           need;
    logic [W-1:0] pop, we;
  } exp_t;

  // Reference rename of the bundle currently on the inputs.
  function automatic exp_t model(input logic fire_e);
    exp_t e;
    logic [W-1:0] al;
    logic [A-1:0] s1, s2;
    logic f1, f2;
    int n;
    e.b.lv = in_lane_valid; e.b.rd = '0; e.b.rs1 = '0; e.b.rs2 = '0;
    e.b.rs1v = '0; e.b.rs2v = '0; e.b.rob = '0; e.pop = '0; e.we = '0;
    al = '0;
    n = 0;
    for (int i = 0; i < W; i++) begin
      al[i] = in_lane_valid[i] && in_rd_arch[i*A +: A] != '0;
      if (al[i]) begin
        e.b.rd[i*P +: P] = fl_free_idx[n*P +: P];
        n++;
      end
    end
    e.need = n;
    for (int i = 0; i < W; i++) begin
      if (in_lane_valid[i]) begin
        s1 = in_rs1_arch[i*A +: A];
        s2 = in_rs2_arch[i*A +: A];
        e.b.rs1[i*P +: P] = rat_phy_f(s1); e.b.rs1v[i] = rat_rdy_f(s1); f1 = 1'b0;
        e.b.rs2[i*P +: P] = rat_phy_f(s2); e.b.rs2v[i] = rat_rdy_f(s2); f2 = 1'b0;
        for (int j = i - 1; j >= 0; j--) begin
          if (!f1 && al[j] && s1 != '0 && in_rd_arch[j*A +: A] == s1) begin
            e.b.rs1[i*P +: P] = e.b.rd[j*P +: P]; e.b.rs1v[i] = 1'b0; f1 = 1'b1;
          end
          if (!f2 && al[j] && s2 != '0 && in_rd_arch[j*A +: A] == s2) begin
            e.b.rs2[i*P +: P] = e.b.rd[j*P +: P]; e.b.rs2v[i] = 1'b0; f2 = 1'b1;
          end
        end
        e.b.rob[i*R +: R] = rob_id[i*R +: R];
      end
    end
    for (int k = 0; k < W; k++) e.pop[k] = fire_e && (k < n);
    for (int i = 0; i < W; i++) begin
      e.we[i] = fire_e && al[i];
      for (int k = i + 1; k < W; k++)
        if (al[k] && in_rd_arch[k*A +: A] == in_rd_arch[i*A +: A]) e.we[i] = 1'b0;
    end
    return e;
  endfunction

  int total = 0;
  int bad = 0;
  bit mon_en = 1'b0;
  bundle_t sb[$];
  exp_t m_e;
  logic m_ov, m_fok, m_space, m_ir, m_fire, m_rv;
  int es_fl = 0, es_rob = 0, es_out = 0;

  // Scoreboard monitor: samples at negedge, away from the active edge.
  always @(negedge clk) begin
    if (mon_en) begin
      m_ov = (sb.size() != 0);
      total++;
      if (out_valid !== m_ov) begin
        bad++; $display("FAIL mon_out_valid got=%b want=%b t=%0t", out_valid, m_ov, $time);
      end
      if (m_ov) begin
        total++;
        if ({out_lane_valid, out_rd_phy, out_rs1_phy, out_rs2_phy, out_rs1_valid, out_rs2_valid, out_rob_id}
            !== {sb[0].lv, sb[0].rd, sb[0].rs1, sb[0].rs2, sb[0].rs1v, sb[0].rs2v, sb[0].rob}) begin
          bad++;
          $display("FAIL mon_payload got=%h/%h/%h/%h want=%h/%h/%h/%h t=%0t", out_lane_valid, out_rd_phy,
                   out_rs1_phy, out_rs2_phy, sb[0].lv, sb[0].rd, sb[0].rs1, sb[0].rs2, $time);
        end
      end
      m_e     = model(1'b0);
      m_fok   = int'(fl_avail_cnt) >= m_e.need;
      m_space = !m_ov || out_ready;
      m_ir    = !flush && rob_ready && m_fok && m_space;
      m_fire  = in_valid && m_ir;
      m_rv    = in_valid && !flush && m_fok && m_space;
      m_e     = model(m_fire);
      total++;
      if ({in_ready, rob_valid, fl_pop, rat_we} !== {m_ir, m_rv, m_e.pop, m_e.we}) begin
        bad++;
        $display("FAIL mon_ctrl got ir=%b rv=%b pop=%b we=%b want ir=%b rv=%b pop=%b we=%b t=%0t",
                 in_ready, rob_valid, fl_pop, rat_we, m_ir, m_rv, m_e.pop, m_e.we, $time);
      end
      total++;
      if ({rat_waddr, rat_wphy} !== {in_rd_arch, m_e.b.rd}) begin
        bad++;
        $display("FAIL mon_rat_w got=%h/%h want=%h/%h", rat_waddr, rat_wphy, in_rd_arch, m_e.b.rd);
      end
`ifdef RENAME_STATS_EN
      total++;
      if ({stat_stall_fl, stat_stall_rob, stat_stall_out} !== {32'(es_fl), 32'(es_rob), 32'(es_out)}) begin
        bad++;
        $display("FAIL mon_stats got=%0d/%0d/%0d want=%0d/%0d/%0d", stat_stall_fl, stat_stall_rob,
                 stat_stall_out, es_fl, es_rob, es_out);
      end
`endif
      if (!rst) begin
        sb.delete();
        es_fl = 0; es_rob = 0; es_out = 0;
      end else begin
        if (in_valid && !m_fire && !flush) begin
          if (!m_fok) es_fl++;
          if (!rob_ready) es_rob++;
          if (!m_space) es_out++;
        end
        if (m_ov && (flush || out_ready)) void'(sb.pop_front());
        if (m_fire) sb.push_back(m_e.b);
      end
    end
  end

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic set_bundle(input logic [W-1:0] lv, input logic [W*A-1:0] rd, s1, s2,
                            input logic [W*P-1:0] fl, input logic [1:0] avail);
    in_valid = 1'b1; in_lane_valid = lv; in_rd_arch = rd; in_rs1_arch = s1; in_rs2_arch = s2;
    fl_free_idx = fl; fl_avail_cnt = avail;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (2) cyc();
    total++;
    if ({out_valid, out_lane_valid, out_rd_phy, out_rs1_phy, out_rs2_phy, out_rob_id} !== '0) begin
      bad++; $display("FAIL reset_outputs got ov=%b rd=%h", out_valid, out_rd_phy);
    end
    total++;
    if ({in_ready, fl_pop, rat_we, rob_valid} !== {1'b1, 2'b00, 2'b00, 1'b0}) begin
      bad++; $display("FAIL reset_comb got ir=%b pop=%b we=%b rv=%b want 1/00/00/0", in_ready, fl_pop, rat_we, rob_valid);
    end
    rst = 1'b1;
    mon_en = 1'b1;
  endtask

  task automatic test_rob_stall();
    set_bundle(2'b11, {5'd2, 5'd1}, {5'd3, 5'd4}, {5'd0, 5'd0}, {6'd21, 6'd20}, 2'd2);
    rob_id = {5'd1, 5'd0}; rob_ready = 1'b0;
    #1;
    total++;
    if ({in_ready, rob_valid, fl_pop} !== {1'b0, 1'b1, 2'b00}) begin
      bad++; $display("FAIL rob_stall_comb got ir=%b rv=%b pop=%b want 0/1/00", in_ready, rob_valid, fl_pop);
    end
    cyc(); cyc();
    rob_ready = 1'b1;
    cyc();
    in_valid = 1'b0;
    total++;
    if (out_rd_phy !== {6'd21, 6'd20}) begin
      bad++; $display("FAIL rob_stall_out got=%h want=%h", out_rd_phy, {6'd21, 6'd20});
    end
`ifdef RENAME_STATS_EN
    total++;
    if (stat_stall_rob !== 32'd2) begin
      bad++; $display("FAIL rob_stall_count got=%0d want=2", stat_stall_rob);
    end
`endif
  endtask

  task automatic test_bypass();
    set_bundle(2'b11, {5'd6, 5'd5}, {5'd5, 5'd1}, {5'd3, 5'd2}, {6'd34, 6'd33}, 2'd2);
    rob_id = {5'd9, 5'd8};
    #1;
    total++;
    if ({fl_pop, rat_we, rat_wphy} !== {2'b11, 2'b11, 6'd34, 6'd33}) begin
      bad++; $display("FAIL bypass_comb got pop=%b we=%b wphy=%h want 11/11/%h", fl_pop, rat_we, rat_wphy, {6'd34, 6'd33});
    end
    cyc();
    in_valid = 1'b0;
    total++;
    if ({out_valid, out_rd_phy} !== {1'b1, 6'd34, 6'd33}) begin
      bad++; $display("FAIL bypass_rd got ov=%b rd=%h want 1/%h", out_valid, out_rd_phy, {6'd34, 6'd33});
    end
    total++;
    if ({out_rs1_phy, out_rs1_valid, out_rs2_phy, out_rs2_valid, out_rob_id}
        !== {6'd33, 6'd11, 2'b01, 6'd13, 6'd12, 2'b11, 5'd9, 5'd8}) begin
      bad++; $display("FAIL bypass_src got rs1=%h v=%b rs2=%h v=%b rob=%h", out_rs1_phy, out_rs1_valid,
                      out_rs2_phy, out_rs2_valid, out_rob_id);
    end
  endtask

  task automatic test_waw();
    set_bundle(2'b11, {5'd7, 5'd7}, {5'd7, 5'd1}, {5'd0, 5'd0}, {6'd41, 6'd40}, 2'd2);
    #1;
    total++;
    if ({rat_we, rat_wphy[2*P-1:P]} !== {2'b10, 6'd41}) begin
      bad++; $display("FAIL waw_we got we=%b wphy1=%0d want 10/41", rat_we, rat_wphy[2*P-1:P]);
    end
    cyc();
    in_valid = 1'b0;
    total++;
    if ({out_rd_phy, out_rs1_phy[2*P-1:P], out_rs1_valid[1]} !== {6'd41, 6'd40, 6'd40, 1'b0}) begin
      bad++; $display("FAIL waw_out got rd=%h rs1_1=%0d v=%b", out_rd_phy, out_rs1_phy[2*P-1:P], out_rs1_valid[1]);
    end
  endtask

  task automatic test_fl_stall();
    set_bundle(2'b11, {5'd9, 5'd8}, {5'd2, 5'd1}, {5'd2, 5'd1}, {6'd46, 6'd45}, 2'd1);
    #1;
    total++;
    if ({in_ready, fl_pop, rob_valid} !== {1'b0, 2'b00, 1'b0}) begin
      bad++; $display("FAIL fl_stall_comb got ir=%b pop=%b rv=%b want 0/00/0", in_ready, fl_pop, rob_valid);
    end
    cyc();
    total++;
    if (out_valid !== 1'b0) begin
      bad++; $display("FAIL fl_stall_ov got=%b want=0", out_valid);
    end
    fl_avail_cnt = 2'd2;
    cyc();
    in_valid = 1'b0;
    total++;
    if ({out_valid, out_rd_phy} !== {1'b1, 6'd46, 6'd45}) begin
      bad++; $display("FAIL fl_stall_fire got ov=%b rd=%h", out_valid, out_rd_phy);
    end
  endtask

  task automatic test_out_stall();
    set_bundle(2'b11, {5'd11, 5'd10}, {5'd1, 5'd1}, {5'd1, 5'd1}, {6'd48, 6'd47}, 2'd2);
    out_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      total++;
      if ({in_ready, out_valid, out_rd_phy} !== {1'b0, 1'b1, 6'd46, 6'd45}) begin
        bad++; $display("FAIL out_stall_hold c=%0d got ir=%b ov=%b rd=%h", c, in_ready, out_valid, out_rd_phy);
      end
      cyc();
    end
    out_ready = 1'b1;
    cyc();
    in_valid = 1'b0;
    total++;
    if ({out_valid, out_rd_phy} !== {1'b1, 6'd48, 6'd47}) begin
      bad++; $display("FAIL out_stall_next got ov=%b rd=%h", out_valid, out_rd_phy);
    end
  endtask

  task automatic test_x0();
    set_bundle(2'b11, {5'd3, 5'd0}, {5'd1, 5'd2}, {5'd1, 5'd2}, {6'd0, 6'd50}, 2'd1);
    #1;
    total++;
    if ({fl_pop, rat_we} !== {2'b01, 2'b10}) begin
      bad++; $display("FAIL x0_comb got pop=%b we=%b want 01/10", fl_pop, rat_we);
    end
    cyc();
    in_valid = 1'b0;
    total++;
    if (out_rd_phy !== {6'd50, 6'd0}) begin
      bad++; $display("FAIL x0_rd got=%h want=%h", out_rd_phy, {6'd50, 6'd0});
    end
  endtask

  task automatic test_need_zero();
    set_bundle(2'b01, {5'd4, 5'd0}, {5'd6, 5'd3}, {5'd7, 5'd17}, '0, 2'd0);
    rob_id = {5'd12, 5'd11};
    #1;
    total++;
    if ({in_ready, fl_pop} !== {1'b1, 2'b00}) begin
      bad++; $display("FAIL need0_comb got ir=%b pop=%b want 1/00", in_ready, fl_pop);
    end
    cyc();
    in_valid = 1'b0;
    total++;
    if ({out_lane_valid, out_rd_phy, out_rs1_phy, out_rs1_valid, out_rs2_phy, out_rs2_valid, out_rob_id}
        !== {2'b01, 12'd0, 6'd0, 6'd13, 2'b01, 6'd0, 6'd27, 2'b00, 5'd0, 5'd11}) begin
      bad++; $display("FAIL need0_out got lv=%b rs1=%h rs2=%h rob=%h", out_lane_valid, out_rs1_phy, out_rs2_phy, out_rob_id);
    end
  endtask

  task automatic test_flush();
    set_bundle(2'b11, {5'd13, 5'd12}, {5'd1, 5'd1}, {5'd1, 5'd1}, {6'd52, 6'd51}, 2'd2);
    cyc();
    out_ready = 1'b0;
    set_bundle(2'b11, {5'd15, 5'd14}, {5'd1, 5'd1}, {5'd1, 5'd1}, {6'd54, 6'd53}, 2'd2);
    flush = 1'b1;
    #1;
    total++;
    if ({in_ready, fl_pop, rat_we, rob_valid} !== {1'b0, 2'b00, 2'b00, 1'b0}) begin
      bad++; $display("FAIL flush_comb got ir=%b pop=%b we=%b rv=%b", in_ready, fl_pop, rat_we, rob_valid);
    end
    cyc();
    flush = 1'b0;
    total++;
    if ({out_valid, out_rd_phy} !== {1'b0, 6'd52, 6'd51}) begin
      bad++; $display("FAIL flush_kill got ov=%b rd=%h", out_valid, out_rd_phy);
    end
    cyc();
    total++;
    if ({out_valid, out_rd_phy} !== {1'b1, 6'd54, 6'd53}) begin
      bad++; $display("FAIL flush_refill got ov=%b rd=%h", out_valid, out_rd_phy);
    end
    rst = 1'b0;
    cyc();
    rst = 1'b1;
    in_valid = 1'b0;
    total++;
    if ({out_valid, out_lane_valid, out_rd_phy, out_rs1_phy, out_rs2_phy, out_rs1_valid,
         out_rs2_valid, out_rob_id} !== '0) begin
      bad++; $display("FAIL stall_reset got ov=%b lv=%b rd=%h", out_valid, out_lane_valid, out_rd_phy);
    end
    out_ready = 1'b1;
  endtask

  task automatic test_back_to_back();
    for (int c = 0; c < 80; c++) begin
      in_valid      = ($urandom_range(0, 9) < 8);
      in_lane_valid = W'($urandom_range(0, 3));
      for (int i = 0; i < W; i++) begin
        in_rd_arch[i*A +: A]  = A'($urandom_range(0, 7));
        in_rs1_arch[i*A +: A] = A'($urandom_range(0, 7));
        in_rs2_arch[i*A +: A] = A'($urandom_range(0, 31));
        fl_free_idx[i*P +: P] = P'($urandom_range(32, 63));
        rob_id[i*R +: R]      = R'($urandom_range(0, 31));
      end
      fl_avail_cnt = 2'($urandom_range(0, 2));
      rob_ready    = ($urandom_range(0, 9) < 8);
      out_ready    = (c < 20) ? 1'b1 : ($urandom_range(0, 3) != 0);
      flush        = ($urandom_range(0, 19) == 0);
      cyc();
    end
    in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1; rob_ready = 1'b1;
    repeat (3) cyc();
  endtask

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b0; flush = 1'b0; in_valid = 1'b0; in_lane_valid = '0;
    in_rd_arch = '0; in_rs1_arch = '0; in_rs2_arch = '0; fl_free_idx = '0;
    fl_avail_cnt = '0; rob_ready = 1'b1; rob_id = '0; out_ready = 1'b1;
    test_reset();
    test_rob_stall();
    test_bypass();
    test_waw();
    test_fl_stall();
    test_out_stall();
    test_x0();
    test_need_zero();
    test_flush();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
